// File: rtl/gs_state_machine.sv
// gs_state_machine: pops host commands, sweeps raw-signal addresses 0..N and streams samples.
// Optional build macro GS_CMD_FILTER_EN drops popped commands whose selector is 0x00.
module gs_state_machine (
  input  logic        iClk,
  input  logic        iReset,
  input  logic [31:0] iGS_wdata,
  input  logic        iGS_wren,
  output logic        oGS_wfull,
  input  logic [15:0] i16Reg,
  output logic [7:0]  o8Addr,
  output logic [7:0]  o8SignSelec,
  output logic        oWriteRawSignal,
  output logic [15:0] o16RawSignal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LATCH,
    S_STREAM,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_addr;
  logic [7:0]  r_last;
  logic [7:0]  r_sel;
  logic        r_wr;
  logic [15:0] r_raw;
  logic        w_cmd_ok;
  logic        w_unused;

`ifdef GS_CMD_FILTER_EN
  assign w_cmd_ok = (iGS_wdata[31:24] != 8'h00);
`else
  assign w_cmd_ok = 1'b1;
`endif

  // Reserved command bits carry no meaning here.
  assign w_unused = ^iGS_wdata[23:8];

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (!iGS_wren) w_next = S_FETCH;
      S_FETCH:  w_next = S_WAIT;
      S_WAIT:   w_next = S_LATCH;
      S_LATCH:  w_next = w_cmd_ok ? S_STREAM : S_IDLE;
      S_STREAM: if (r_addr == r_last) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Sample stage: the strobe and data registered here trail the presented address by one cycle.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_addr <= 8'd0;
      r_last <= 8'd0;
      r_sel  <= 8'd0;
      r_wr   <= 1'b0;
      r_raw  <= 16'd0;
    end else begin
      r_wr <= (r_state == S_STREAM);
      unique case (r_state)
        S_STREAM: begin
          r_raw  <= i16Reg;
          r_addr <= r_addr + 8'd1;
        end
        S_LATCH: begin
          r_addr <= 8'd0;
          if (w_cmd_ok) begin
            r_sel  <= iGS_wdata[31:24];
            r_last <= iGS_wdata[7:0];
          end
        end
        default: r_addr <= 8'd0;
      endcase
    end
  end

  assign oGS_wfull       = (r_state == S_FETCH);
  assign o8Addr          = r_addr;
  assign o8SignSelec     = r_sel;
  assign oWriteRawSignal = r_wr;
  assign o16RawSignal    = r_raw;

endmodule

// File: tb/tb_gs_state_machine.sv
// Randomised self-checking bench for gs_state_machine with a queue-based FIFO and stream model.
module tb_gs_state_machine;

  logic        iClk = 1'b0;
  logic        iReset;
  logic [31:0] iGS_wdata;
  logic        iGS_wren;
  logic        oGS_wfull;
  logic [15:0] i16Reg;
  logic [7:0]  o8Addr;
  logic [7:0]  o8SignSelec;
  logic        oWriteRawSignal;
  logic [15:0] o16RawSignal;

  gs_state_machine dut (
    .iClk            (iClk),
    .iReset          (iReset),
    .iGS_wdata       (iGS_wdata),
    .iGS_wren        (iGS_wren),
    .oGS_wfull       (oGS_wfull),
    .i16Reg          (i16Reg),
    .o8Addr          (o8Addr),
    .o8SignSelec     (o8SignSelec),
    .oWriteRawSignal (oWriteRawSignal),
    .o16RawSignal    (o16RawSignal)
  );

  always #5 iClk = ~iClk;

  // Stand-in for the raw-signal ROM: any fixed scrambling of {selector, address}.
  function automatic logic [15:0] rom(input logic [7:0] s, input logic [7:0] a);
    logic [31:0] p;
    p = {16'd0, s, a} * 32'd40503;
    return p[15:0] ^ 16'h3C5A;
  endfunction

  assign i16Reg = rom(o8SignSelec, o8Addr);

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int fall_cyc = 0;

  logic [31:0] fq[$];
  logic [31:0] pend;
  int          pend_dly = 0;
  logic [7:0]  prev_addr = 8'd0;

  int          pop_cyc[$];
  int          strobe_cyc[$];
  logic [15:0] obs_data[$];
  logic [7:0]  obs_addr[$];
  logic [7:0]  obs_sel[$];

  logic [15:0] exp_data[$];
  logic [7:0]  exp_addr[$];
  logic [7:0]  exp_sel[$];
  logic [7:0]  m_sel = 8'd0;

  // Reference: a command yields samples 0..N of its selector, unless filtered out.
  task automatic model_cmd(input logic [31:0] c);
    logic [7:0] s;
    logic [7:0] n;
    s = c[31:24];
    n = c[7:0];
`ifdef GS_CMD_FILTER_EN
    if (s == 8'h00) return;
`endif
    m_sel = s;
    for (int k = 0; k <= int'(n); k++) begin
      exp_data.push_back(rom(s, 8'(k)));
      exp_addr.push_back(8'(k));
      exp_sel.push_back(s);
    end
  endtask

  task automatic clear_queues();
    pop_cyc.delete();
    strobe_cyc.delete();
    obs_data.delete();
    obs_addr.delete();
    obs_sel.delete();
    exp_data.delete();
    exp_addr.delete();
    exp_sel.delete();
  endtask

  // One clock: observe outputs mid-cycle and play the standard-mode FIFO.
  task automatic tick();
    @(negedge iClk);
    cyc++;
    if (oWriteRawSignal) begin
      strobe_cyc.push_back(cyc);
      obs_data.push_back(o16RawSignal);
      obs_addr.push_back(prev_addr);
      obs_sel.push_back(o8SignSelec);
    end
    prev_addr = o8Addr;
    if (pend_dly == 1) begin
      iGS_wdata = pend;
      pend_dly  = 0;
    end
    if (oGS_wfull) begin
      pop_cyc.push_back(cyc);
      if (fq.size() > 0) begin
        pend      = fq.pop_front();
        pend_dly  = 1;
        iGS_wdata = $urandom();
      end
      iGS_wren = (fq.size() == 0);
    end
  endtask

  task automatic push(input logic [31:0] c);
    if (fq.size() == 0) fall_cyc = cyc;
    fq.push_back(c);
    iGS_wren = 1'b0;
    model_cmd(c);
  endtask

  task automatic run_until_idle(input int max, output bit timed_out);
    int quiet;
    quiet = 0;
    timed_out = 1'b1;
    for (int i = 0; i < max; i++) begin
      tick();
      if (fq.size() == 0 && !oWriteRawSignal && !oGS_wfull && pend_dly == 0) quiet++;
      else quiet = 0;
      if (quiet >= 8) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    iGS_wren = 1'b1;
    iGS_wdata = 32'd0;
    repeat (3) tick();
    vectors++;
    if ({oGS_wfull, oWriteRawSignal, o8Addr, o8SignSelec, o16RawSignal} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs: got wfull=%b wr=%b addr=%h sel=%h raw=%h, expected all 0",
               oGS_wfull, oWriteRawSignal, o8Addr, o8SignSelec, o16RawSignal);
    end
    iReset = 1'b0;
    clear_queues();
    repeat (20) tick();
    vectors++;
    if (pop_cyc.size() !== 0) begin
      errors++;
      $display("FAIL idle_no_pop: got %0d pops, expected 0", pop_cyc.size());
    end
    vectors++;
    if ({strobe_cyc.size() != 0, o8Addr, o8SignSelec, o16RawSignal} !== 33'd0) begin
      errors++;
      $display("FAIL idle_outputs: got strobes=%0d addr=%h sel=%h raw=%h, expected none/0",
               strobe_cyc.size(), o8Addr, o8SignSelec, o16RawSignal);
    end
  endtask

  task automatic test_full_sweep();
    bit to;
    clear_queues();
    push(32'h1EFFFFFF);
    run_until_idle(400, to);
    vectors++;
    if (to) begin errors++; $display("FAIL sweep_timeout: got timeout, expected idle"); end
    vectors++;
    if (pop_cyc.size() !== 1) begin
      errors++; $display("FAIL sweep_pops: got %0d, expected 1", pop_cyc.size());
    end
    vectors++;
    if (obs_data.size() !== 256) begin
      errors++; $display("FAIL sweep_count: got %0d strobes, expected 256", obs_data.size());
    end
    for (int k = 0; k < obs_data.size() && k < exp_data.size(); k++) begin
      vectors++;
      if (obs_data[k] !== exp_data[k] || obs_addr[k] !== exp_addr[k] || obs_sel[k] !== exp_sel[k]) begin
        errors++;
        $display("FAIL sweep_sample[%0d]: got data=%h addr=%h sel=%h, expected %h %h %h",
                 k, obs_data[k], obs_addr[k], obs_sel[k], exp_data[k], exp_addr[k], exp_sel[k]);
      end
    end
    vectors++;
    if (strobe_cyc.size() == 256 && strobe_cyc[255] - strobe_cyc[0] !== 255) begin
      errors++; $display("FAIL sweep_contiguous: got span %0d, expected 255", strobe_cyc[255] - strobe_cyc[0]);
    end
    vectors++;
    if ({o8Addr, o8SignSelec} !== {8'h00, 8'h1E}) begin
      errors++; $display("FAIL sweep_end: got addr=%h sel=%h, expected 00 1e", o8Addr, o8SignSelec);
    end
  endtask

  task automatic test_short_latency();
    bit to;
    clear_queues();
    push(32'h28FFFF03);
    run_until_idle(60, to);
    vectors++;
    if (to) begin errors++; $display("FAIL short_timeout: got timeout, expected idle"); end
    vectors++;
    if (obs_data.size() !== 4) begin
      errors++; $display("FAIL short_count: got %0d strobes, expected 4", obs_data.size());
    end
    for (int k = 0; k < obs_data.size() && k < exp_data.size(); k++) begin
      vectors++;
      if (obs_data[k] !== exp_data[k] || obs_addr[k] !== exp_addr[k] || obs_sel[k] !== exp_sel[k]) begin
        errors++;
        $display("FAIL short_sample[%0d]: got data=%h addr=%h sel=%h, expected %h %h %h",
                 k, obs_data[k], obs_addr[k], obs_sel[k], exp_data[k], exp_addr[k], exp_sel[k]);
      end
    end
    vectors++;
    if (strobe_cyc.size() > 0 && strobe_cyc[0] - fall_cyc !== 5) begin
      errors++; $display("FAIL short_latency: got %0d cycles, expected 5", strobe_cyc[0] - fall_cyc);
    end
    vectors++;
    if (pop_cyc.size() !== 1 || (pop_cyc.size() > 0 && pop_cyc[0] - fall_cyc !== 1)) begin
      errors++; $display("FAIL short_pop: got %0d pops, expected one pulse 1 cycle after empty falls", pop_cyc.size());
    end
    vectors++;
    if (o8SignSelec !== 8'h28) begin
      errors++; $display("FAIL short_sel: got %h, expected 28", o8SignSelec);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    clear_queues();
    push(32'h1EFFFF01);
    push(32'h32FFFF01);
    run_until_idle(80, to);
    vectors++;
    if (to) begin errors++; $display("FAIL b2b_timeout: got timeout, expected idle"); end
    vectors++;
    if (pop_cyc.size() !== 2 || strobe_cyc.size() !== 4) begin
      errors++; $display("FAIL b2b_counts: got %0d pops %0d strobes, expected 2 and 4", pop_cyc.size(), strobe_cyc.size());
    end
    for (int k = 0; k < obs_data.size() && k < exp_data.size(); k++) begin
      vectors++;
      if (obs_data[k] !== exp_data[k] || obs_addr[k] !== exp_addr[k] || obs_sel[k] !== exp_sel[k]) begin
        errors++;
        $display("FAIL b2b_sample[%0d]: got data=%h addr=%h sel=%h, expected %h %h %h",
                 k, obs_data[k], obs_addr[k], obs_sel[k], exp_data[k], exp_addr[k], exp_sel[k]);
      end
    end
    if (pop_cyc.size() == 2 && strobe_cyc.size() == 4) begin
      vectors++;
      if (pop_cyc[1] - strobe_cyc[1] < 2) begin
        errors++; $display("FAIL b2b_second_pop: got %0d cycles after last strobe, expected >= 2", pop_cyc[1] - strobe_cyc[1]);
      end
      vectors++;
      if (strobe_cyc[2] - pop_cyc[1] !== 4) begin
        errors++; $display("FAIL b2b_second_latency: got %0d, expected 4", strobe_cyc[2] - pop_cyc[1]);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    bit to;
    clear_queues();
    push(32'h3C00AA40);
    for (int i = 0; i < 60 && strobe_cyc.size() < 10; i++) tick();
    vectors++;
    if (strobe_cyc.size() < 10) begin
      errors++; $display("FAIL midrst_start: got %0d strobes, expected >= 10", strobe_cyc.size());
    end
    iReset = 1'b1;
    #1;
    vectors++;
    if ({oGS_wfull, oWriteRawSignal, o8Addr, o8SignSelec, o16RawSignal} !== 34'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got wfull=%b wr=%b addr=%h sel=%h raw=%h, expected all 0",
               oGS_wfull, oWriteRawSignal, o8Addr, o8SignSelec, o16RawSignal);
    end
    repeat (2) tick();
    iReset = 1'b0;
    pend_dly = 0;
    m_sel = 8'd0;
    clear_queues();
    repeat (20) tick();
    vectors++;
    if (pop_cyc.size() !== 0 || strobe_cyc.size() !== 0) begin
      errors++; $display("FAIL midrst_idle: got %0d pops %0d strobes, expected 0 and 0", pop_cyc.size(), strobe_cyc.size());
    end
    push(32'h5AFFFF02);
    run_until_idle(60, to);
    vectors++;
    if (to || obs_data.size() !== exp_data.size()) begin
      errors++; $display("FAIL midrst_resume: got %0d strobes (timeout=%0d), expected %0d", obs_data.size(), to, exp_data.size());
    end
    for (int k = 0; k < obs_data.size() && k < exp_data.size(); k++) begin
      vectors++;
      if (obs_data[k] !== exp_data[k] || obs_addr[k] !== exp_addr[k] || obs_sel[k] !== exp_sel[k]) begin
        errors++;
        $display("FAIL midrst_sample[%0d]: got data=%h addr=%h sel=%h, expected %h %h %h",
                 k, obs_data[k], obs_addr[k], obs_sel[k], exp_data[k], exp_addr[k], exp_sel[k]);
      end
    end
  endtask

  task automatic test_selector_zero();
    bit to;
    clear_queues();
    push(32'h00FFFF03);
    run_until_idle(60, to);
    vectors++;
    if (to || pop_cyc.size() !== 1) begin
      errors++; $display("FAIL zero_pop: got %0d pops (timeout=%0d), expected 1", pop_cyc.size(), to);
    end
    vectors++;
    if (obs_data.size() !== exp_data.size()) begin
      errors++; $display("FAIL zero_count: got %0d strobes, expected %0d", obs_data.size(), exp_data.size());
    end
    vectors++;
    if (o8SignSelec !== m_sel) begin
      errors++; $display("FAIL zero_sel: got %h, expected %h", o8SignSelec, m_sel);
    end
  endtask

  task automatic test_random();
    bit to;
    int n_cmd;
    logic [31:0] c;
    for (int r = 0; r < 8; r++) begin
      clear_queues();
      n_cmd = $urandom_range(1, 3);
      for (int j = 0; j < n_cmd; j++) begin
        c = $urandom();
        c[7:0] = 8'($urandom_range(0, 12));
        if (r == 3 && j == 0) c[31:24] = 8'h00;
        push(c);
      end
      run_until_idle(200, to);
      vectors++;
      if (to || pop_cyc.size() !== n_cmd) begin
        errors++; $display("FAIL rand%0d_pops: got %0d (timeout=%0d), expected %0d", r, pop_cyc.size(), to, n_cmd);
      end
      vectors++;
      if (obs_data.size() !== exp_data.size()) begin
        errors++; $display("FAIL rand%0d_count: got %0d strobes, expected %0d", r, obs_data.size(), exp_data.size());
      end
      for (int k = 0; k < obs_data.size() && k < exp_data.size(); k++) begin
        vectors++;
        if (obs_data[k] !== exp_data[k] || obs_addr[k] !== exp_addr[k] || obs_sel[k] !== exp_sel[k]) begin
          errors++;
          $display("FAIL rand%0d_sample[%0d]: got data=%h addr=%h sel=%h, expected %h %h %h",
                   r, k, obs_data[k], obs_addr[k], obs_sel[k], exp_data[k], exp_addr[k], exp_sel[k]);
        end
      end
      vectors++;
      if (o8SignSelec !== m_sel) begin
        errors++; $display("FAIL rand%0d_sel: got %h, expected %h", r, o8SignSelec, m_sel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_short_latency();
    test_back_to_back();
    test_reset_mid_stream();
    test_selector_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
